// File: rtl/sram_if_pkg.sv
// Shared definitions for sram-like request streams: size encodings,
// master-count bound and an index-width helper.
package sram_if_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int MAX_MASTERS = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_order_fifo.sv
// Small synchronous FIFO with occupancy count; pop data is the current head,
// visible combinationally before the pop takes effect.
module sram_order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags, qualified enables and head read-out.
  always_comb begin
    empty     = (count_r == '0);
    full      = (count_r == CNT_W'(DEPTH));
    rd_en_s   = pop & ~empty;
    // a pop frees the slot a simultaneous push writes into, so full may still accept
    wr_en_s   = push & (~full | rd_en_s);
    head_data = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (rd_en_s) rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/sram_arbiter_nx1.sv
// N-master to 1-slave sram-like arbiter: zero-cycle request muxing with grant
// lock, and in-order return of data_ok to the issuing master.
module sram_arbiter_nx1
  import sram_if_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [N_MASTERS-1:0]        m_req,
  input  logic [N_MASTERS-1:0]        m_wr,
  input  logic [2*N_MASTERS-1:0]      m_size,
  input  logic [ADDR_W*N_MASTERS-1:0] m_addr,
  input  logic [DATA_W*N_MASTERS-1:0] m_wdata,
  output logic [N_MASTERS-1:0]        m_addr_ok,
  output logic [N_MASTERS-1:0]        m_data_ok,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        s_req,
  output logic                        s_wr,
  output logic [1:0]                  s_size,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_addr_ok,
  input  logic                        s_data_ok,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic                        err_orphan
);

  localparam int IDX_W = idx_w(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic             any_req_s;
  logic             handshake_s;
  logic             pop_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic [IDX_W-1:0] winner_s;
  logic [IDX_W-1:0] head_idx_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             lock_r;
  logic [IDX_W-1:0] lock_idx_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic             err_orphan_r;

  // Free arbitration: scan from the highest candidate down so the first
  // requester in priority order is the last one written.
  always_comb begin
    int cand_v;
    cand_v    = 0;
    arb_idx_s = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        cand_v = k;
      end else begin
        cand_v = ((int'(rr_ptr_r) + k) >= N_MASTERS) ? (int'(rr_ptr_r) + k - N_MASTERS)
                                                     : (int'(rr_ptr_r) + k);
      end
      arb_idx_s = m_req[cand_v] ? IDX_W'(cand_v) : arb_idx_s;
    end
  end

  // Request path: winner selection, slave mux and per-master handshake.
  always_comb begin
    any_req_s   = |m_req;
    winner_s    = lock_r ? lock_idx_r : arb_idx_s;
    // holding off while in reset keeps acceptance from leaking into a discarded state
    s_req       = resetn & any_req_s & (fifo_count_s < CNT_W'(MAX_OUTST));
    handshake_s = s_req & s_addr_ok;
    s_wr        = 1'b0;
    s_size      = 2'b00;
    s_addr      = '0;
    s_wdata     = '0;
    m_addr_ok   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      logic sel_v;
      sel_v        = any_req_s & (winner_s == IDX_W'(i));
      s_wr         = s_wr | (sel_v & m_wr[i]);
      s_size       = s_size | ({2{sel_v}} & m_size[2*i +: 2]);
      s_addr       = s_addr | ({ADDR_W{sel_v}} & m_addr[i*ADDR_W +: ADDR_W]);
      s_wdata      = s_wdata | ({DATA_W{sel_v}} & m_wdata[i*DATA_W +: DATA_W]);
      m_addr_ok[i] = handshake_s & (winner_s == IDX_W'(i));
    end
  end

  // Completion path: route data_ok to the oldest outstanding master.
  always_comb begin
    pop_s      = s_data_ok & ~fifo_empty_s;
    m_rdata    = s_rdata;
    err_orphan = err_orphan_r;
    m_data_ok  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_data_ok[i] = pop_s & (head_idx_s == IDX_W'(i));
    end
  end

  sram_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (handshake_s & ~fifo_full_s),
    .push_data (winner_s),
    .pop       (pop_s),
    .head_data (head_idx_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Grant lock: a presented but unaccepted request keeps its winner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else if (handshake_s) begin
      lock_r     <= 1'b0;
    end else if (s_req) begin
      lock_r     <= 1'b1;
      lock_idx_r <= winner_s;
    end
  end

  // Round-robin pointer advances past each accepted winner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_r <= '0;
    end else if ((ARB_MODE == 1) && handshake_s) begin
      rr_ptr_r <= (winner_s == IDX_W'(N_MASTERS - 1)) ? '0 : (winner_s + IDX_W'(1));
    end
  end

  // Sticky flag for a completion with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_orphan_r <= 1'b0;
    end else begin
      err_orphan_r <= err_orphan_r | (s_data_ok & fifo_empty_s);
    end
  end

endmodule

// File: tb/tb_sram_arbiter_nx1.sv
// Scoreboard bench: stimulus queues expected grants and completions, monitors
// pop and compare whenever a DUT presents m_addr_ok / m_data_ok.
module tb_sram_arbiter_nx1;
  import sram_if_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [N-1:0]    a_m_req, a_m_wr, a_m_addr_ok, a_m_data_ok;
  logic [2*N-1:0]  a_m_size;
  logic [AW*N-1:0] a_m_addr;
  logic [DW*N-1:0] a_m_wdata;
  logic [DW-1:0]   a_m_rdata, a_s_wdata, a_s_rdata;
  logic            a_s_req, a_s_wr, a_s_addr_ok, a_s_data_ok, a_err;
  logic [1:0]      a_s_size;
  logic [AW-1:0]   a_s_addr;

  logic [N-1:0]    b_m_req, b_m_wr, b_m_addr_ok, b_m_data_ok;
  logic [2*N-1:0]  b_m_size;
  logic [AW*N-1:0] b_m_addr;
  logic [DW*N-1:0] b_m_wdata;
  logic [DW-1:0]   b_m_rdata, b_s_wdata, b_s_rdata;
  logic            b_s_req, b_s_wr, b_s_addr_ok, b_s_data_ok, b_err;
  logic [1:0]      b_s_size;
  logic [AW-1:0]   b_s_addr;

  sram_arbiter_nx1 #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(4), .ARB_MODE(1)) dut_a (
    .clk(clk), .resetn(resetn), .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_addr_ok(a_m_addr_ok), .m_data_ok(a_m_data_ok),
    .m_rdata(a_m_rdata), .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_addr(a_s_addr),
    .s_wdata(a_s_wdata), .s_addr_ok(a_s_addr_ok), .s_data_ok(a_s_data_ok), .s_rdata(a_s_rdata),
    .err_orphan(a_err));

  sram_arbiter_nx1 #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(2), .ARB_MODE(0)) dut_b (
    .clk(clk), .resetn(resetn), .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok),
    .m_rdata(b_m_rdata), .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_addr(b_s_addr),
    .s_wdata(b_s_wdata), .s_addr_ok(b_s_addr_ok), .s_data_ok(b_s_data_ok), .s_rdata(b_s_rdata),
    .err_orphan(b_err));

  int   n_checks = 0;
  int   n_errors = 0;
  int   gq_a[$];
  int   gq_b[$];
  exp_t dq_a[$];
  exp_t dq_b[$];
  int   a_g, b_g;
  exp_t a_e, b_e;

  localparam logic [31:0] TAG1 = 32'hD00D_0000;
  localparam logic [31:0] TAG6 = 32'h6600_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_a(input int i, input logic wr, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    a_m_wr[i] = wr; a_m_size[2*i +: 2] = sz; a_m_addr[i*AW +: AW] = ad; a_m_wdata[i*DW +: DW] = wd;
  endtask

  task automatic drive_a(input logic [2:0] req, input logic ok, input logic dok, input logic [31:0] rd);
    @(posedge clk); #1;
    a_m_req = req; a_s_addr_ok = ok; a_s_data_ok = dok; a_s_rdata = rd;
  endtask

  task automatic drive_b(input logic [2:0] req, input logic ok, input logic dok, input logic [31:0] rd);
    @(posedge clk); #1;
    b_m_req = req; b_s_addr_ok = ok; b_s_data_ok = dok; b_s_rdata = rd;
  endtask

  // Monitor for instance A: grants and completions against the queues.
  always @(negedge clk) begin
    if (a_m_addr_ok != 3'b000) begin
      if (gq_a.size() == 0) check("a_grant_unexpected", 64'(a_m_addr_ok), 64'd0);
      else begin a_g = gq_a.pop_front(); check("a_grant", 64'(a_m_addr_ok), 64'd1 << a_g); end
    end
    if (a_m_data_ok != 3'b000) begin
      if (dq_a.size() == 0) check("a_data_ok_unexpected", 64'(a_m_data_ok), 64'd0);
      else begin
        a_e = dq_a.pop_front();
        check("a_data_ok_idx", 64'(a_m_data_ok), 64'd1 << a_e.idx);
        check("a_rdata", 64'(a_m_rdata), 64'(a_e.data));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (b_m_addr_ok != 3'b000) begin
      if (gq_b.size() == 0) check("b_grant_unexpected", 64'(b_m_addr_ok), 64'd0);
      else begin b_g = gq_b.pop_front(); check("b_grant", 64'(b_m_addr_ok), 64'd1 << b_g); end
    end
    if (b_m_data_ok != 3'b000) begin
      if (dq_b.size() == 0) check("b_data_ok_unexpected", 64'(b_m_data_ok), 64'd0);
      else begin
        b_e = dq_b.pop_front();
        check("b_data_ok_idx", 64'(b_m_data_ok), 64'd1 << b_e.idx);
        check("b_rdata", 64'(b_m_rdata), 64'(b_e.data));
      end
    end
  end

  initial begin
    resetn = 1'b0;
    a_m_req = '0; a_m_wr = '0; a_m_size = '0; a_m_addr = '0; a_m_wdata = '0;
    a_s_addr_ok = 1'b0; a_s_data_ok = 1'b0; a_s_rdata = '0;
    b_m_req = '0; b_m_wr = '0; b_s_addr_ok = 1'b0; b_s_data_ok = 1'b0; b_s_rdata = '0;
    b_m_size = {SIZE_WORD, SIZE_HALF, SIZE_BYTE};
    b_m_addr = {32'h0000_C200, 32'h0000_B100, 32'h0000_A000};
    b_m_wdata = {32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
    for (int i = 0; i < N; i++) set_a(i, 1'b0, SIZE_WORD, 32'h1000_0000 + 32'(i) * 32'h100, 32'hA000_0000 + 32'(i));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_s_req", 64'(a_s_req), 64'd0);
    check("rst_a_addr_ok", 64'(a_m_addr_ok), 64'd0);
    check("rst_a_data_ok", 64'(a_m_data_ok), 64'd0);
    check("rst_a_err", 64'(a_err), 64'd0);
    check("rst_a_s_addr", 64'(a_s_addr), 64'd0);
    check("rst_b_s_req", 64'(b_s_req), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Test 1: round-robin, addr_ok every cycle, data_ok two cycles later
    for (int k = 0; k < 6; k++) dq_a.push_back('{k % 3, TAG1 + 32'(k)});
    for (int c = 0; c < 8; c++) begin
      drive_a((c < 6) ? 3'b111 : 3'b000, c < 6, c >= 2, (c >= 2) ? TAG1 + 32'(c - 2) : 32'h0);
      if (c < 6) gq_a.push_back(c % 3);
      @(negedge clk);
      check("t1_s_req", 64'(a_s_req), 64'(c < 6));
    end
    drive_a(3'b000, 1'b0, 1'b0, 32'h0);

    // Test 4: orphan data_ok after reset
    @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    check("t4_rst_s_wdata", 64'(a_s_wdata), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    drive_a(3'b000, 1'b0, 1'b1, 32'h5555_AAAA);
    @(negedge clk);
    check("t4_no_data_ok", 64'(a_m_data_ok), 64'd0);
    check("t4_err_before_edge", 64'(a_err), 64'd0);
    drive_a(3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t4_err_set", 64'(a_err), 64'd1);
    drive_a(3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t4_err_sticky", 64'(a_err), 64'd1);
    #2 resetn = 1'b0;
    #1 check("t4_err_async_clear", 64'(a_err), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Test 5: write from master 2 then read from master 0
    set_a(2, 1'b1, SIZE_WORD, 32'hBFAF_F000, 32'h1234_5678);
    set_a(0, 1'b0, SIZE_WORD, 32'h1FC0_0010, 32'hDEAD_BEEF);
    set_a(1, 1'b1, SIZE_BYTE, 32'h2222_0001, 32'h0000_0011);
    dq_a.push_back('{2, 32'hCAFE_0002});
    dq_a.push_back('{0, 32'h8765_4321});
    drive_a(3'b100, 1'b1, 1'b0, 32'h0);
    gq_a.push_back(2);
    @(negedge clk);
    check("t5_w_s_req", 64'(a_s_req), 64'd1);
    check("t5_w_s_wr", 64'(a_s_wr), 64'd1);
    check("t5_w_s_size", 64'(a_s_size), 64'd2);
    check("t5_w_s_addr", 64'(a_s_addr), 64'hBFAF_F000);
    check("t5_w_s_wdata", 64'(a_s_wdata), 64'h1234_5678);
    drive_a(3'b001, 1'b1, 1'b0, 32'h0);
    gq_a.push_back(0);
    @(negedge clk);
    check("t5_r_s_wr", 64'(a_s_wr), 64'd0);
    check("t5_r_s_addr", 64'(a_s_addr), 64'h1FC0_0010);
    drive_a(3'b000, 1'b0, 1'b1, 32'hCAFE_0002);
    drive_a(3'b000, 1'b0, 1'b1, 32'h8765_4321);
    drive_a(3'b000, 1'b0, 1'b0, 32'h0);

    // Test 6: reset with three outstanding (rr pointer now at 1)
    for (int c = 0; c < 3; c++) begin
      drive_a(3'b111, 1'b1, 1'b0, 32'h0);
      gq_a.push_back((c + 1) % 3);
    end
    drive_a(3'b111, 1'b1, 1'b1, 32'h0BAD_0BAD);
    resetn = 1'b0;
    #1;
    check("t6_rst_addr_ok", 64'(a_m_addr_ok), 64'd0);
    check("t6_rst_data_ok", 64'(a_m_data_ok), 64'd0);
    check("t6_rst_s_req", 64'(a_s_req), 64'd0);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      drive_a(3'b111, 1'b1, 1'b0, 32'h0);
      resetn = 1'b1;
      gq_a.push_back(c % 3);
      @(negedge clk);
      check("t6_refill_s_req", 64'(a_s_req), 64'd1);
    end
    drive_a(3'b111, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("t6_full_s_req", 64'(a_s_req), 64'd0);
    check("t6_full_addr_ok", 64'(a_m_addr_ok), 64'd0);
    for (int k = 0; k < 4; k++) dq_a.push_back('{k % 3, TAG6 + 32'(k)});
    for (int k = 0; k < 4; k++) drive_a(3'b000, 1'b0, 1'b1, TAG6 + 32'(k));
    drive_a(3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t6_err_clear", 64'(a_err), 64'd0);

    // Test 2: fixed priority with grant lock
    drive_b(3'b110, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t2_s_req", 64'(b_s_req), 64'd1);
    check("t2_first_addr", 64'(b_s_addr), 64'h0000_B100);
    for (int c = 0; c < 3; c++) begin
      drive_b(3'b111, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t2_locked_addr", 64'(b_s_addr), 64'h0000_B100);
      check("t2_locked_size", 64'(b_s_size), 64'd1);
    end
    dq_b.push_back('{1, 32'hB0B0_0001});
    dq_b.push_back('{0, 32'hB0B0_0002});
    dq_b.push_back('{0, 32'hB0B0_0003});
    dq_b.push_back('{2, 32'hB0B0_0004});
    drive_b(3'b111, 1'b1, 1'b0, 32'h0);
    gq_b.push_back(1);
    drive_b(3'b101, 1'b1, 1'b0, 32'h0);
    gq_b.push_back(0);
    @(negedge clk);
    check("t2_next_addr", 64'(b_s_addr), 64'h0000_A000);

    // Test 3: full FIFO blocks, pop reopens, push+pop keeps count
    for (int c = 0; c < 2; c++) begin
      drive_b(3'b101, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("t3_full_s_req", 64'(b_s_req), 64'd0);
      check("t3_full_addr_ok", 64'(b_m_addr_ok), 64'd0);
    end
    drive_b(3'b101, 1'b1, 1'b1, 32'hB0B0_0001);
    @(negedge clk);
    check("t3_pop_s_req_same_cycle", 64'(b_s_req), 64'd0);
    drive_b(3'b101, 1'b1, 1'b1, 32'hB0B0_0002);
    gq_b.push_back(0);
    @(negedge clk);
    check("t3_reopen_s_req", 64'(b_s_req), 64'd1);
    drive_b(3'b100, 1'b1, 1'b0, 32'h0);
    gq_b.push_back(2);
    @(negedge clk);
    check("t3_last_slot_s_req", 64'(b_s_req), 64'd1);
    drive_b(3'b100, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("t3_refull_s_req", 64'(b_s_req), 64'd0);
    drive_b(3'b000, 1'b0, 1'b1, 32'hB0B0_0003);
    drive_b(3'b000, 1'b0, 1'b1, 32'hB0B0_0004);
    drive_b(3'b000, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    check("end_gq_a_empty", 64'(gq_a.size()), 64'd0);
    check("end_dq_a_empty", 64'(dq_a.size()), 64'd0);
    check("end_gq_b_empty", 64'(gq_b.size()), 64'd0);
    check("end_dq_b_empty", 64'(dq_b.size()), 64'd0);
    check("end_b_err", 64'(b_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
